// File: rtl/commit_trace_tx.sv
// commit_trace_tx: commit-trace FIFO streaming retired {pc, rd, data, seq} records to a valid/ready sink.
// Define COMMIT_TRACE_STALL_EN to drive stall_req from occupancy; otherwise it is tied 0.
module commit_trace_tx #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [4:0]      trace_rd,
  output logic [XLEN-1:0] trace_data,
  output logic [15:0]     trace_seq,
  output logic            stall_req,
  output logic [7:0]      drop_cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_HI = (AW+1)'(DEPTH - 1);
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] data_mem_q [DEPTH];
  logic [4:0] rd_mem_q [DEPTH];
  logic [15:0] seq_mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic [15:0] seq_q, seq_d;
  logic [7:0] drop_q, drop_d;
  logic full, empty, push, pop;
  always_comb begin
    full = count_q == CNT_FULL;
    empty = count_q == '0;
    pop = !empty && trace_ready;
    push = wb_valid && (!full || pop);
    head_d = pop ? head_q + 1'b1 : head_q;
    tail_d = push ? tail_q + 1'b1 : tail_q;
    count_d = (push && !pop) ? count_q + 1'b1 : (pop && !push) ? count_q - 1'b1 : count_q;
    seq_d = wb_valid ? seq_q + 16'd1 : seq_q;
    drop_d = (wb_valid && !push && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      seq_q <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      seq_q <= seq_d;
      drop_q <= drop_d;
    end
  end
  // Storage needs no reset: outputs are masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q] <= wb_pc;
      rd_mem_q[tail_q] <= wb_we ? wb_rd : 5'd0;
      data_mem_q[tail_q] <= wb_we ? wb_data : '0;
      seq_mem_q[tail_q] <= seq_q;
    end
  end
  assign trace_valid = !empty;
  assign trace_pc = empty ? '0 : pc_mem_q[head_q];
  assign trace_rd = empty ? 5'd0 : rd_mem_q[head_q];
  assign trace_data = empty ? '0 : data_mem_q[head_q];
  assign trace_seq = empty ? 16'd0 : seq_mem_q[head_q];
  assign drop_cnt = drop_q;
`ifdef COMMIT_TRACE_STALL_EN
  assign stall_req = count_q >= CNT_HI;
`else
  assign stall_req = 1'b0;
`endif
endmodule

// File: tb/tb_commit_trace_tx.sv
// tb_commit_trace_tx: directed self-checking bench for commit_trace_tx (DEPTH=8, XLEN=32).
module tb_commit_trace_tx;
`ifdef COMMIT_TRACE_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic wb_valid = 1'b0, wb_we = 1'b0, trace_ready = 1'b0;
  logic [31:0] wb_pc = '0, wb_data = '0;
  logic [4:0] wb_rd = '0;
  logic trace_valid, stall_req;
  logic [31:0] trace_pc, trace_data;
  logic [4:0] trace_rd;
  logic [15:0] trace_seq;
  logic [7:0] drop_cnt;
  int checks = 0, failures = 0;
  commit_trace_tx #(.DEPTH(8), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_rd(trace_rd), .trace_data(trace_data), .trace_seq(trace_seq),
    .stall_req(stall_req), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic retire(input logic [31:0] pc, input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_valid = 1'b1;
    wb_pc = pc;
    wb_we = we;
    wb_rd = rd;
    wb_data = data;
    tick();
    wb_valid = 1'b0;
  endtask
  initial begin
    int rx;
    int gaps;
    logic [15:0] last_seq;
    tick();
    tick();
    chk("rst_valid", trace_valid, 0);
    chk("rst_pc", trace_pc, 0);
    chk("rst_rd", trace_rd, 0);
    chk("rst_data", trace_data, 0);
    chk("rst_seq", trace_seq, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();
    trace_ready = 1'b1;
    retire(32'h4, 1'b1, 5'd10, 32'd55);
    chk("first_valid", trace_valid, 1);
    chk("first_pc", trace_pc, 32'h4);
    chk("first_rd", trace_rd, 10);
    chk("first_data", trace_data, 55);
    chk("first_seq", trace_seq, 0);
    tick();
    chk("first_popped", trace_valid, 0);
    trace_ready = 1'b0;
    retire(32'h8, 1'b0, 5'd5, 32'h1234);
    chk("nowe_valid", trace_valid, 1);
    chk("nowe_pc", trace_pc, 32'h8);
    chk("nowe_rd", trace_rd, 0);
    chk("nowe_data", trace_data, 0);
    chk("nowe_seq", trace_seq, 1);
    tick();
    chk("nowe_hold_pc", trace_pc, 32'h8);
    chk("nowe_hold_valid", trace_valid, 1);
    trace_ready = 1'b1;
    tick();
    chk("nowe_popped", trace_valid, 0);
    trace_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      retire(32'h100 + 32'(4 * i), 1'b1, 5'(i + 1), 32'(i * 17));
      chk($sformatf("fill_stall_%0d", i + 1), stall_req, STALL_EN && (i + 1 >= 7));
    end
    retire(32'h1F0, 1'b1, 5'd31, 32'hDEAD);
    chk("drop_cnt_1", drop_cnt, 1);
    chk("full_head_seq", trace_seq, 0);
    tick();
    chk("hold_seq", trace_seq, 0);
    chk("hold_pc", trace_pc, 32'h100);
    chk("hold_data", trace_data, 0);
    trace_ready = 1'b1;
    retire(32'h200, 1'b1, 5'd20, 32'hABC);
    trace_ready = 1'b0;
    chk("pp_drop", drop_cnt, 1);
    chk("pp_stall", stall_req, STALL_EN);
    chk("pp_head_seq", trace_seq, 1);
    trace_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("drain_seq_%0d", i), trace_seq, 32'(i));
      chk($sformatf("drain_pc_%0d", i), trace_pc, 32'h100 + 32'(4 * i));
      tick();
    end
    chk("pp_new_seq", trace_seq, 9);
    chk("pp_new_pc", trace_pc, 32'h200);
    chk("pp_new_rd", trace_rd, 20);
    chk("pp_new_data", trace_data, 32'hABC);
    tick();
    chk("drained", trace_valid, 0);
    rst = 1'b1;
    #1;
    chk("rst_clears_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    rx = 0;
    gaps = 0;
    last_seq = 16'hAAAA;
    wb_valid = 1'b1;
    wb_we = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      wb_pc = 32'(i);
      tick();
      if (trace_valid) begin
        if (trace_seq !== 16'(rx)) gaps++;
        last_seq = trace_seq;
        rx++;
      end
    end
    wb_valid = 1'b0;
    tick();
    chk("wrap_rx", rx, 65537);
    chk("wrap_gaps", gaps, 0);
    chk("wrap_last_seq", last_seq, 0);
    chk("wrap_drop", drop_cnt, 0);
    chk("wrap_empty", trace_valid, 0);
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) retire(32'h300 + 32'(i), 1'b1, 5'd1, 32'(i));
    chk("mid_valid", trace_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", trace_valid, 0);
    chk("mid_rst_seq", trace_seq, 0);
    chk("mid_rst_drop", drop_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    retire(32'h40, 1'b1, 5'd3, 32'd7);
    chk("post_rst_valid", trace_valid, 1);
    chk("post_rst_seq", trace_seq, 0);
    chk("post_rst_pc", trace_pc, 32'h40);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
